// File: rtl/text_rx_deframer.sv
// text_rx_deframer: hunts for the sync word in a hard-decision bitstream,
// extracts a length-prefixed payload, checks its XOR checksum and hands the
// payload bytes to the sink through a small FIFO with a valid/ready handshake.
// FIFO_DEPTH is expected to be a power of two and at least 2.
module text_rx_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA5C3,
  parameter int          MAX_LEN    = 64,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]     MAX_V   = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    S_HUNT,
    S_LEN,
    S_DATA,
    S_CHK
  } state_t;

  state_t           state;
  // Only the 15 most recent bits are kept: the 16th bit of the window is
  // always the incoming bit_in itself.
  logic [14:0]      shreg;
  logic [4:0]       hunt_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       field_sr;
  logic [7:0]       byte_cnt;
  logic [7:0]       acc;
  logic             ovf;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [7:0]       field_byte;
  logic             field_end;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             sync_hit;

  // The byte being completed by this bit, and the handshake/FIFO decisions
  assign field_byte = {field_sr, bit_in};
  assign field_end  = bit_valid && (state != S_HUNT) && (bit_cnt == 3'd7);
  assign push_req   = field_end && (state == S_DATA);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid && byte_ready;
  assign fifo_full  = (count == DEPTH_V);
  // A full FIFO still accepts a byte when the head leaves on the same edge
  assign push       = push_req && (!fifo_full || pop);
  assign sync_hit   = (hunt_cnt >= 5'd15) && ({shreg, bit_in} == SYNC_WORD);
  // Head is forced to zero while empty so outputs read 0 straight out of reset
  assign byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;

  // Frame FSM: sync hunt, length, payload and checksum fields, status pulses
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= S_HUNT;
      shreg      <= '0;
      hunt_cnt   <= '0;
      bit_cnt    <= '0;
      field_sr   <= '0;
      byte_cnt   <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_valid) begin
        if (state == S_HUNT) begin
          if (sync_hit) begin
            state   <= S_LEN;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end else begin
            shreg <= {shreg[13:0], bit_in};
            if (hunt_cnt != 5'd16) hunt_cnt <= hunt_cnt + 5'd1;
          end
        end else begin
          field_sr <= field_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              S_LEN: begin
                if ((field_byte == 8'd0) || (field_byte > MAX_V)) begin
                  frame_err <= 1'b1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  state     <= S_HUNT;
                  busy      <= 1'b0;
                  shreg     <= '0;
                  hunt_cnt  <= '0;
                  ovf       <= 1'b0;
                end else begin
                  byte_cnt <= field_byte;
                  acc      <= '0;
                  state    <= S_DATA;
                end
              end
              S_DATA: begin
                // Dropped bytes still enter the checksum; the frame fails anyway
                acc      <= acc ^ field_byte;
                byte_cnt <= byte_cnt - 8'd1;
                if (fifo_full && !pop) ovf <= 1'b1;
                if (byte_cnt == 8'd1) state <= S_CHK;
              end
              S_CHK: begin
                if ((field_byte == acc) && !ovf) begin
                  frame_done <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
                state    <= S_HUNT;
                busy     <= 1'b0;
                shreg    <= '0;
                hunt_cnt <= '0;
                ovf      <= 1'b0;
              end
              default: state <= S_HUNT;
            endcase
          end
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: data only, gated by occupancy on the read side
  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= field_byte;
  end

endmodule
